instr_mem_responder: RTL and testbench

//   Memory-side responder for instruction fetch/write requests issued by the

---
 rtl/instr_mem_responder.sv | 99 +++++++++
 tb/tb_instr_mem_responder.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/instr_mem_responder.sv
// Memory-side responder for instruction fetch/write requests: one request in
// flight, fixed access latency, one-cycle ACK with RDATA/MISALIGN held until the next ACK.
module instr_mem_responder #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              wr_i,
  input  logic [31:0]       addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              ack_o,
  output logic              busy_o,
  output logic              misalign_o
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                cap, access;
  logic                wr_q, mis_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q, misrd_unused;
  logic                misalign_q;
  logic [DATA_W-1:0]   mem [2**ADDR_W];

  // Address bits above the word index wrap silently.
  logic unused_addr;
  assign unused_addr  = ^addr_i[31:ADDR_W+2];
  assign misrd_unused = '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    access  = 1'b0;
    case (state_q)
      IDLE: if (req_i) begin
        cap     = 1'b1;
        cnt_d   = CNT_INIT;
        state_d = WAIT;
      end
      WAIT: if (cnt_q != 4'd0) begin
        cnt_d = cnt_q - 4'd1;
      end else begin
        access  = 1'b1;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      mis_q      <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cap) begin
        wr_q    <= wr_i;
        mis_q   <= |addr_i[1:0];
        idx_q   <= addr_i[ADDR_W+1:2];
        wdata_q <= wdata_i;
      end
      if (access) begin
        misalign_q <= mis_q;
        if (mis_q)     rdata_q <= misrd_unused;
        else if (wr_q) rdata_q <= wdata_q;
        else           rdata_q <= mem[idx_q];
      end
    end
  end

  // RAM has no reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk_i) begin
    if (!rst_i && access && wr_q && !mis_q)
      mem[idx_q] <= wdata_q;
  end

  assign rdata_o    = rdata_q;
  assign misalign_o = misalign_q;
  assign ack_o      = (state_q == RESP);
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_instr_mem_responder.sv
// Randomized self-checking bench for instr_mem_responder against a
// transaction-level memory model.
module tb_instr_mem_responder;
  localparam int ADDR_W = 6, DATA_W = 32, LATENCY = 2;

  logic              clk = 1'b0, rst = 1'b1, req = 1'b0, wr = 1'b0;
  logic [31:0]       addr = '0;
  logic [DATA_W-1:0] wdata = '0, rdata;
  logic              ack, busy, misalign;

  int n_chk = 0, n_fail = 0;
  logic [DATA_W-1:0] mem_m [2**ADDR_W];
  bit                known [2**ADDR_W];

  instr_mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(LATENCY)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .wr_i(wr), .addr_i(addr),
    .wdata_i(wdata), .rdata_o(rdata), .ack_o(ack), .busy_o(busy),
    .misalign_o(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // One full transaction; expectations come from the word-array model.
  task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d);
    int idx, n;
    bit mis, chk_rd;
    logic [31:0] exp_rd;
    idx    = int'(a[ADDR_W+1:2]);
    mis    = (a[1:0] != 2'b00);
    exp_rd = mis ? 32'h0 : (w ? d : mem_m[idx]);
    chk_rd = mis || w || known[idx];
    if (w && !mis) begin mem_m[idx] = d; known[idx] = 1'b1; end
    @(negedge clk);
    req = 1'b1; wr = w; addr = a; wdata = d;
    step();
    req = 1'b0; wr = 1'($urandom); addr = $urandom; wdata = $urandom;
    chk("busy_wait", {31'b0, busy}, 32'd1);
    n = 0;
    do begin step(); n++; end while (!ack && n < 20);
    chk("ack_lat", n, LATENCY);
    chk("misalign", {31'b0, misalign}, {31'b0, mis});
    if (chk_rd) chk("rdata", rdata, exp_rd);
    step();
    chk("ack_pulse", {31'b0, ack}, 32'd0);
    chk("busy_idle", {31'b0, busy}, 32'd0);
    if (chk_rd) chk("rdata_hold", rdata, exp_rd);
  endtask

  initial begin
    int acks, lows, n, gap;
    int ack_t [3];
    logic [31:0] a;

    // Reset
    step();
    rst = 1'b0;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ack", {31'b0, ack}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_mis", {31'b0, misalign}, 32'd0);

    // Basic write/read, wrap, misaligned
    txn(1'b1, 32'h0000_0010, 32'h0030_0093);
    txn(1'b0, 32'h0000_0010, 32'h0);
    chk("rd_0x10", rdata, 32'h0030_0093);
    txn(1'b1, 32'h0000_0104, 32'hDEAD_BEEF);
    txn(1'b0, 32'h0000_0004, 32'h0);
    chk("wrap_rd", rdata, 32'hDEAD_BEEF);
    txn(1'b1, 32'h0000_0012, 32'h1234_5678);
    chk("mis_flag", {31'b0, misalign}, 32'd1);
    txn(1'b0, 32'h0000_0010, 32'h0);
    chk("mis_nowr", rdata, 32'h0030_0093);

    // REQ held high: three back-to-back reads
    @(negedge clk);
    req = 1'b1; wr = 1'b0; addr = 32'h0000_0010;
    acks = 0; lows = 0; n = 0;
    while (acks < 3 && n < 40) begin
      step(); n++;
      if (ack) begin
        ack_t[acks] = n;
        chk("b2b_rdata", rdata, 32'h0030_0093);
        acks++;
        if (acks == 3) req = 1'b0;
      end else if (!busy && acks > 0) lows++;
    end
    chk("b2b_acks", acks, 3);
    chk("b2b_gap1", ack_t[1] - ack_t[0], LATENCY + 2);
    chk("b2b_gap2", ack_t[2] - ack_t[1], LATENCY + 2);
    chk("b2b_low", lows, 2);
    req = 1'b0;
    repeat (3) step();
    chk("b2b_stop", {31'b0, busy}, 32'd0);

    // Reset aborts a write in WAIT
    txn(1'b1, 32'h0000_0020, 32'h1111_2222);
    @(negedge clk);
    req = 1'b1; wr = 1'b1; addr = 32'h0000_0020; wdata = 32'hFFFF_FFFF;
    step();
    req = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_ack", {31'b0, ack}, 32'd0);
    chk("abort_rdata", rdata, 32'h0);
    acks = 0;
    repeat (6) begin step(); if (ack) acks++; end
    chk("abort_noack", acks, 0);
    txn(1'b0, 32'h0000_0020, 32'h0);
    chk("abort_keep", rdata, 32'h1111_2222);

    // RST and REQ on the same edge: request must not be accepted
    @(negedge clk);
    req = 1'b1; rst = 1'b1;
    step();
    req = 1'b0; rst = 1'b0;
    chk("rstreq_busy", {31'b0, busy}, 32'd0);

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      a = $urandom;
      a[ADDR_W+1:2] = 6'($urandom_range(0, 7));
      a[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      txn(1'($urandom), a, $urandom);
      gap = $urandom_range(0, 2);
      repeat (gap) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
